// File: rtl/idu_pkg.sv
// Shared decode definitions: opcodes, inst_type one-hot encoding, EBREAK word.
package idu_pkg;

    // Base RV32/RV64 opcodes
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpAluImm  = 7'b0010011;
    localparam logic [6:0] OpAluReg  = 7'b0110011;
    localparam logic [6:0] OpSystem  = 7'b1110011;
    // RV64-only word ops
    localparam logic [6:0] OpAluImmW = 7'b0011011;
    localparam logic [6:0] OpAluRegW = 7'b0111011;

    // Bit positions inside the inst_type one-hot vector
    localparam int unsigned IdxR = 5;
    localparam int unsigned IdxI = 4;
    localparam int unsigned IdxS = 3;
    localparam int unsigned IdxB = 2;
    localparam int unsigned IdxU = 1;
    localparam int unsigned IdxJ = 0;

    localparam logic [5:0] TypeNone = 6'b000000;
    localparam logic [5:0] TypeR    = 6'b100000;
    localparam logic [5:0] TypeI    = 6'b010000;
    localparam logic [5:0] TypeS    = 6'b001000;
    localparam logic [5:0] TypeB    = 6'b000100;
    localparam logic [5:0] TypeU    = 6'b000010;
    localparam logic [5:0] TypeJ    = 6'b000001;

    localparam logic [31:0] InstEbreak = 32'h0010_0073;

endpackage

// File: rtl/idu_queue_stage_if.sv
// Fetch-side valid/ready handshake carrying one {pc, inst} pair.
interface idu_queue_stage_if #(
    parameter int unsigned PC_W = 64
) ();

    logic            valid;
    logic            ready;
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);

endinterface

// File: rtl/idu_decode.sv
// Combinational instruction classifier and XLEN-wide immediate generator.
module idu_decode
    import idu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     inst_i,
    output logic [5:0]      inst_type_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] imm_u_o,
    output logic            illegal_o,
    output logic            is_ebreak_o
);

    logic [6:0]  opcode;
    logic [11:0] imm_i_raw;
    logic [11:0] imm_s_raw;
    logic [12:0] imm_b_raw;
    logic [31:0] imm_u_raw;
    logic [20:0] imm_j_raw;

    assign opcode    = inst_i[6:0];
    assign imm_i_raw = inst_i[31:20];
    assign imm_s_raw = {inst_i[31:25], inst_i[11:7]};
    assign imm_b_raw = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u_raw = {inst_i[31:12], 12'b0};
    assign imm_j_raw = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    assign is_ebreak_o = (inst_i == InstEbreak);

    // Classify the opcode; W-ops are only legal on a 64-bit datapath.
    always_comb begin
        inst_type_o = TypeNone;
        illegal_o   = 1'b0;
        case (opcode)
            OpLui, OpAuipc:                      inst_type_o = TypeU;
            OpJal:                               inst_type_o = TypeJ;
            OpJalr, OpLoad, OpAluImm, OpSystem:  inst_type_o = TypeI;
            OpBranch:                            inst_type_o = TypeB;
            OpStore:                             inst_type_o = TypeS;
            OpAluReg:                            inst_type_o = TypeR;
            OpAluImmW: begin
                if (XLEN == 64) inst_type_o = TypeI;
                else            illegal_o   = 1'b1;
            end
            OpAluRegW: begin
                if (XLEN == 64) inst_type_o = TypeR;
                else            illegal_o   = 1'b1;
            end
            default:                             illegal_o   = 1'b1;
        endcase
    end

    // Select the immediate field; R-type and illegal fall through to zero.
    always_comb begin
        imm_o   = '0;
        imm_u_o = '0;
        unique case (1'b1)
            inst_type_o[IdxI]: begin
                imm_o   = XLEN'($signed(imm_i_raw));
                imm_u_o = XLEN'(imm_i_raw);
            end
            inst_type_o[IdxS]: begin
                imm_o   = XLEN'($signed(imm_s_raw));
                imm_u_o = XLEN'(imm_s_raw);
            end
            inst_type_o[IdxB]: begin
                imm_o   = XLEN'($signed(imm_b_raw));
                imm_u_o = XLEN'(imm_b_raw);
            end
            inst_type_o[IdxU]: begin
                imm_o   = XLEN'($signed(imm_u_raw));
                imm_u_o = XLEN'(imm_u_raw);
            end
            inst_type_o[IdxJ]: begin
                imm_o   = XLEN'($signed(imm_j_raw));
                imm_u_o = XLEN'(imm_j_raw);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/idu_queue_stage.sv
// Decode stage: DEPTH-entry {pc, inst} queue between IFU and EXU, decoding the head entry.
module idu_queue_stage
    import idu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    idu_queue_stage_if.slave in_if,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PC_W-1:0]  out_pc_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [2:0]       funct3_o,
    output logic [6:0]       funct7_o,
    output logic [6:0]       opcode_o,
    output logic [5:0]       inst_type_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [XLEN-1:0]  imm_u_o,
    output logic             illegal_o,
    output logic             is_ebreak_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [31:0]     inst_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic push, pop;
    logic [31:0] head_inst;

    logic [5:0]      dec_type;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_imm_u;
    logic            dec_illegal;
    logic            dec_ebreak;

    // Both flags come straight from the count register, so no ready-to-ready path exists.
    assign in_if.ready = (count_q != DepthCnt);
    assign out_valid_o = (count_q != '0);

    assign push = in_if.valid & in_if.ready;
    assign pop  = out_valid_o & out_ready_i;

    // Pointer/count update; flush wins over any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until validated by count.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            pc_q[wr_ptr_q]   <= in_if.pc;
            inst_q[wr_ptr_q] <= in_if.inst;
        end
    end

    assign head_inst = inst_q[rd_ptr_q];

    idu_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst_i      (head_inst),
        .inst_type_o (dec_type),
        .imm_o       (dec_imm),
        .imm_u_o     (dec_imm_u),
        .illegal_o   (dec_illegal),
        .is_ebreak_o (dec_ebreak)
    );

    // Drive decode outputs from the head entry, zeroed while the queue is empty.
    always_comb begin
        out_pc_o    = '0;
        rs1_o       = '0;
        rs2_o       = '0;
        rd_o        = '0;
        funct3_o    = '0;
        funct7_o    = '0;
        opcode_o    = '0;
        inst_type_o = '0;
        imm_o       = '0;
        imm_u_o     = '0;
        illegal_o   = 1'b0;
        is_ebreak_o = 1'b0;
        if (out_valid_o) begin
            out_pc_o    = pc_q[rd_ptr_q];
            rs1_o       = head_inst[19:15];
            rs2_o       = head_inst[24:20];
            rd_o        = head_inst[11:7];
            funct3_o    = head_inst[14:12];
            funct7_o    = head_inst[31:25];
            opcode_o    = head_inst[6:0];
            inst_type_o = dec_type;
            imm_o       = dec_imm;
            imm_u_o     = dec_imm_u;
            illegal_o   = dec_illegal;
            is_ebreak_o = dec_ebreak;
        end
    end

endmodule
